// File: rtl/stack_pkg.sv
// Shared defaults and operation codes for the descending stack-pointer unit.
package stack_pkg;

    localparam int          ADDR_W_DEF    = 8;
    localparam logic [7:0]  STACK_TOP_DEF = 8'hFF;
    localparam int          DEPTH_DEF     = 80;
    localparam logic [7:0]  STACK_LIMIT   = STACK_TOP_DEF - 8'(DEPTH_DEF);

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_LOAD
    } op_t;

endpackage

// File: rtl/stack_ptr_unit_decode.sv
// Combinational priority decode of stack requests into one operation plus error strobes.
module stack_op_decode
    import stack_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STACK_TOP = STACK_TOP_DEF,
    parameter int                DEPTH     = DEPTH_DEF
) (
    input  logic              push,
    input  logic              pop,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              full,
    input  logic              empty,
    output op_t               op,
    output logic              ovf_hit,
    output logic              unf_hit,
    output logic              lerr_hit
);

    // Distance below the top; values above STACK_TOP wrap to something larger than DEPTH.
    logic [ADDR_W-1:0] load_ofs;
    logic              load_ok;

    assign load_ofs = STACK_TOP - load_val;
    assign load_ok  = (load_ofs <= ADDR_W'(DEPTH));

    always_comb begin
        op       = OP_IDLE;
        ovf_hit  = 1'b0;
        unf_hit  = 1'b0;
        lerr_hit = 1'b0;
        if (load) begin
            if (load_ok) op = OP_LOAD;
            else         lerr_hit = 1'b1;
        end else if (push && pop) begin
            if (!empty) op = OP_REPL;
            else        unf_hit = 1'b1;
        end else if (push) begin
            if (!full) op = OP_PUSH;
            else       ovf_hit = 1'b1;
        end else if (pop) begin
            if (!empty) op = OP_POP;
            else        unf_hit = 1'b1;
        end
    end

endmodule

// File: rtl/stack_ptr_unit.sv
// Descending stack-pointer unit: registered memory address, occupancy and sticky error flags.
module stack_ptr_unit
    import stack_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] STACK_TOP = STACK_TOP_DEF,
    parameter int                DEPTH     = DEPTH_DEF,
    localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] sp,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow,
    output logic              load_err
);

    op_t               op;
    logic              ovf_hit;
    logic              unf_hit;
    logic              lerr_hit;
    logic [ADDR_W-1:0] sp_inc;
    logic [ADDR_W-1:0] sp_dec;
    logic [ADDR_W-1:0] sp_next;
    logic [CNT_W-1:0]  count_next;

    stack_op_decode #(
        .ADDR_W    (ADDR_W),
        .STACK_TOP (STACK_TOP),
        .DEPTH     (DEPTH)
    ) u_decode (
        .push     (push),
        .pop      (pop),
        .load     (load),
        .load_val (load_val),
        .full     (full),
        .empty    (empty),
        .op       (op),
        .ovf_hit  (ovf_hit),
        .unf_hit  (unf_hit),
        .lerr_hit (lerr_hit)
    );

    assign sp_inc = sp + ADDR_W'(1);
    assign sp_dec = sp - ADDR_W'(1);

    always_comb begin
        sp_next = sp;
        case (op)
            OP_LOAD: sp_next = load_val;
            OP_PUSH: sp_next = sp_dec;
            OP_POP:  sp_next = sp_inc;
            default: sp_next = sp;
        endcase
        count_next = CNT_W'(STACK_TOP - sp_next);
    end

    // Flags come from the next count so full/empty are registers, not decode of sp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= STACK_TOP;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            mem_addr  <= '0;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sp    <= sp_next;
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
            case (op)
                OP_PUSH: begin
                    mem_addr  <= sp;
                    mem_we    <= 1'b1;
                    mem_valid <= 1'b1;
                end
                OP_POP: begin
                    mem_addr  <= sp_inc;
                    mem_we    <= 1'b0;
                    mem_valid <= 1'b1;
                end
                OP_REPL: begin
                    mem_addr  <= sp_inc;
                    mem_we    <= 1'b1;
                    mem_valid <= 1'b1;
                end
                default: mem_valid <= 1'b0;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow  <= ovf_hit  | (overflow  & ~clr_err);
            underflow <= unf_hit  | (underflow & ~clr_err);
            load_err  <= lerr_hit | (load_err  & ~clr_err);
        end
    end

endmodule

// File: doc/stack_ptr_unit.md
Name: stack_ptr_unit

Overview:
Parametrised, synchronous hardware stack-pointer unit for the RNBIP-2 datapath. It generates data-memory addresses for PUSH, POP, simultaneous push+pop (replace-top) and SP-load operations on a descending stack (grows from STACK_TOP downward). It tracks occupancy, reports full and empty, and raises sticky overflow and underflow errors. Every output is registered, so it sits directly between the control unit and the data-memory address mux.

Parameters:
ADDR_W, 8, width of SP and memory address
STACK_TOP, 8'hFF, address of first pushed entry (empty SP value)
DEPTH, 80, maximum entries; lowest legal entry address is STACK_TOP-DEPTH+1 (8'hB0 at defaults)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  push request, single-cycle pulse or held
pop  in  1  pop request
load  in  1  load SP from load_val
load_val  in  ADDR_W  new SP value
clr_err  in  1  clears sticky error flags
mem_addr  out  ADDR_W  registered address for the stack access
mem_valid  out  1  mem_addr valid this cycle (one cycle per accepted op)
mem_we  out  1  1 = write (push/replace), 0 = read (pop)
sp  out  ADDR_W  current stack pointer (next free slot)
count  out  $clog2(DEPTH+1)  entries held = STACK_TOP - sp
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
load_err  out  1  sticky: load_val outside legal range

Behaviour:
- Reset (async, rst_n=0): sp=STACK_TOP, count=0, empty=1, full=0, mem_addr=0, mem_valid=0, mem_we=0, all error flags=0. Deassertion is synchronous to clk at the block boundary; the block does not synchronise it internally.
- Evaluation order per rising edge:
  1. load
  2. push&pop
  3. push
  4. pop
  5. idle
- load=1: if STACK_TOP-DEPTH <= load_val <= STACK_TOP, then sp<=load_val and count is updated. Otherwise sp is unchanged and load_err<=1. push/pop are ignored that cycle. mem_valid=0.
- push only:
  - Not full: mem_addr<=sp, mem_we<=1, mem_valid<=1, sp<=sp-1 (post-decrement).
  - Full: no memory access, sp unchanged, overflow<=1.
- pop only:
  - Not empty: sp<=sp+1, mem_addr<=sp+1, mem_we<=0, mem_valid<=1 (pre-increment).
  - Empty: no access, underflow<=1.
- push&pop:
  - Not empty: replace-top. mem_addr<=sp+1, mem_we<=1, mem_valid<=1, sp unchanged.
  - Empty: no access, underflow<=1.
- Latency: mem_addr, mem_valid, mem_we, sp, count, full and empty all reflect an op one cycle after the request edge. Back-to-back ops are accepted every cycle with no bubbles.
- Idle: mem_valid<=0. mem_addr and mem_we hold their last values.
- Arithmetic is ADDR_W-bit unsigned. The range checks make sp wrap-around impossible: sp never leaves [STACK_TOP-DEPTH, STACK_TOP].
- Error flags are sticky until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the flag is set (error wins).
- full and empty are derived from the registered count, so they are glitch-free.
- Reset mid-operation aborts the op. mem_valid drops immediately (async).

Decomposition:
- Package stack_pkg: ADDR_W, STACK_TOP and DEPTH defaults; localparam STACK_LIMIT = STACK_TOP-DEPTH; op-code enum {OP_IDLE, OP_PUSH, OP_POP, OP_REPL, OP_LOAD}.
- One natural sub-module: stack_op_decode. It is combinational and maps push/pop/load plus full/empty to the op enum and error strobes. The parent holds all registers.

Test Plan:
- Reset, then 3 pushes → mem_addr = FF, FE, FD with mem_we=1; sp=FC; count=3; empty=0.
- 80 pushes from reset → sp=AF, full=1, last mem_addr=B0. 81st push → mem_valid=0, sp=AF, overflow=1.
- From sp=FC, pop → mem_addr=FD, mem_we=0, sp=FD. Pop at sp=FF → underflow=1, sp stays FF. Then clr_err → underflow=0.
- push&pop at sp=FD → mem_addr=FE, mem_we=1, sp=FD. push&pop at sp=FF → underflow=1, no access.
- load=1, load_val=C0 → sp=C0, count=63. load_val=A0 → load_err=1, sp stays C0. load together with push → only load applied.
- rst_n dropped mid-push-stream (between clk edges) → sp=FF, mem_valid=0 immediately; after release, first push gives mem_addr=FF.
